// File: rtl/ps2_rx_ctrl.sv
// PS/2 keyboard receive controller: synchronises and filters the PS/2 lines, sequences the
// 11-bit frame and loads code_q on a good frame, flagging parity, framing and timeout errors.
module ps2_rx_ctrl #(
    parameter int unsigned FILTER_LEN  = 8,
    parameter int unsigned TIMEOUT_CYC = 20000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       rx_en,
    output logic [7:0] code_q,
    output logic       code_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);

    localparam int unsigned TmoW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

    logic [1:0]            clk_sync_q;
    logic [1:0]            data_sync_q;
    logic [FILTER_LEN-1:0] hist_q;
    logic                  fclk_q, fclk_d;
    logic                  hist_low, hist_high;
    logic                  fall_tick;
    logic                  rx_bit;

    state_e                state_q, state_d;
    logic [2:0]            bit_cnt_q, bit_cnt_d;
    logic [7:0]            shreg_q, shreg_d;
    logic                  par_q, par_d;
    logic [TmoW-1:0]       tmo_q, tmo_d;
    logic                  tmo_hit;

    logic                  load_en;
    logic                  perr_d;
    logic                  ferr_d;

    // Input synchronisers and clock glitch filter history.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            hist_q      <= '1;
            fclk_q      <= 1'b1;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk};
            data_sync_q <= {data_sync_q[0], ps2_data};
            hist_q      <= {hist_q[FILTER_LEN-2:0], clk_sync_q[1]};
            fclk_q      <= fclk_d;
        end
    end

    assign hist_low  = (hist_q == '0);
    assign hist_high = &hist_q;

    // Filtered level only moves when the whole history agrees; otherwise it holds.
    always_comb begin
        fclk_d = fclk_q;
        if (hist_low) begin
            fclk_d = 1'b0;
        end else if (hist_high) begin
            fclk_d = 1'b1;
        end
    end

    assign fall_tick = fclk_q & hist_low;
    assign rx_bit    = data_sync_q[1];

    // Timeout fires on the cycle the counter would step onto TIMEOUT_CYC.
    assign tmo_hit = (state_q != StIdle) && !fall_tick &&
                     (tmo_q == TmoW'(TIMEOUT_CYC - 1));

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            par_q      <= 1'b0;
            tmo_q      <= '0;
            code_q     <= 8'h00;
            code_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            par_q      <= par_d;
            tmo_q      <= tmo_d;
            if (load_en) begin
                code_q <= shreg_q;
            end
            code_valid <= load_en;
            parity_err <= perr_d;
            frame_err  <= ferr_d;
            busy       <= (state_d != StIdle);
        end
    end

    // Next-state logic.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        par_d     = par_q;
        tmo_d     = '0;
        unique case (state_q)
            StIdle: begin
                if (fall_tick && !rx_bit && rx_en) begin
                    state_d   = StData;
                    bit_cnt_d = '0;
                end
            end
            StData: begin
                if (fall_tick) begin
                    shreg_d   = {rx_bit, shreg_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = StParity;
                    end
                end
            end
            StParity: begin
                if (fall_tick) begin
                    par_d   = rx_bit;
                    state_d = StStop;
                end
            end
            StStop: begin
                if (fall_tick) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (state_q != StIdle) begin
            if (fall_tick) begin
                tmo_d = '0;
            end else if (tmo_hit) begin
                tmo_d   = '0;
                state_d = StIdle;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end
    end

    // Output decode: a stop-bit 0 outranks a parity failure.
    always_comb begin
        load_en = 1'b0;
        perr_d  = 1'b0;
        ferr_d  = 1'b0;
        if (state_q == StStop && fall_tick) begin
            if (!rx_bit) begin
                ferr_d = 1'b1;
            end else if (^shreg_q ^ par_q) begin
                load_en = 1'b1;
            end else begin
                perr_d = 1'b1;
            end
        end
        if (tmo_hit) begin
            ferr_d = 1'b1;
        end
    end

    // Result pulses are mutually exclusive and never last more than one cycle.
    assert property (@(posedge clk) disable iff (reset)
        $onehot0({code_valid, parity_err, frame_err}));
    assert property (@(posedge clk) disable iff (reset)
        (code_valid || parity_err || frame_err) |=> !(code_valid || parity_err || frame_err));

endmodule
